// File: rtl/panxi_if_fetch_pkg.sv
// panxi instruction-fetch shared definitions.
// Widths, hold levels, FSM encoding and the IF/ID bundle.
package panxi_if_fetch_pkg;

    localparam int PANXI_DW   = 32;
    localparam int HOLD_WIDTH = 3;

    localparam logic [HOLD_WIDTH-1:0] HOLD_NONE = 3'd0;
    localparam logic [HOLD_WIDTH-1:0] HOLD_PC   = 3'd1;
    localparam logic [HOLD_WIDTH-1:0] HOLD_IF   = 3'd2;
    localparam logic [HOLD_WIDTH-1:0] HOLD_ID   = 3'd3;

    localparam logic [PANXI_DW-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_FULL = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic [PANXI_DW-1:0] inst;
        logic [PANXI_DW-1:0] addr;
        logic                valid;
    } if_id_t;

    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.inst  = INST_NOP;
        b.addr  = '0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/panxi_if_skid.sv
// One-entry {data, addr} buffer for a fetch response
// that arrived while ID was stalled.
module panxi_if_skid
    import panxi_if_fetch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                clear,
    input  logic [PANXI_DW-1:0] data_in,
    input  logic [PANXI_DW-1:0] addr_in,
    output logic [PANXI_DW-1:0] data,
    output logic [PANXI_DW-1:0] addr,
    output logic                full
);

    logic [PANXI_DW-1:0] data_q;
    logic [PANXI_DW-1:0] addr_q;
    logic                full_q;

    // Capture on load, empty on clear; load wins if both are seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            addr_q <= '0;
            full_q <= 1'b0;
        end else if (load) begin
            data_q <= data_in;
            addr_q <= addr_in;
            full_q <= 1'b1;
        end else if (clear) begin
            data_q <= '0;
            addr_q <= '0;
            full_q <= 1'b0;
        end
    end

    assign data = data_q;
    assign addr = addr_q;
    assign full = full_q;

endmodule

// File: rtl/panxi_if_fetch.sv
// panxi instruction-fetch unit: single-outstanding ibus
// transaction feeding the IF/ID register, flushed by jumps.
module panxi_if_fetch
    import panxi_if_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PANXI_DW-1:0]   inst_addr_xi,
    input  logic                  jmp_en_xi,
    input  logic [HOLD_WIDTH-1:0] hold_flag_xi,
    output logic                  ibus_req_xo,
    output logic [PANXI_DW-1:0]   ibus_addr_xo,
    input  logic                  ibus_gnt_xi,
    input  logic                  ibus_rvalid_xi,
    input  logic [PANXI_DW-1:0]   ibus_rdata_xi,
    output logic                  fetch_hold_req_xo,
    output logic [PANXI_DW-1:0]   inst_xo,
    output logic [PANXI_DW-1:0]   inst_addr_xo,
    output logic                  inst_valid_xo
);

    fetch_state_e        state;
    logic [PANXI_DW-1:0] addr_q;
    if_id_t              if_id_q;
    if_id_t              if_id_d;

    logic                id_stall;
    logic                in_req;
    logic                in_wait;
    logic                in_full;
    logic                gnt_take;
    logic                rsp_take;
    logic                skid_take;
    logic                skid_load;
    logic                skid_clear;
    logic                hold_keep;

    logic [PANXI_DW-1:0] skid_data;
    logic [PANXI_DW-1:0] skid_addr;
    logic                skid_full;

    assign id_stall = (hold_flag_xi >= HOLD_IF);

    assign in_req  = (state == S_REQ);
    assign in_wait = (state == S_WAIT);
    assign in_full = (state == S_FULL);

    assign gnt_take   = in_req && !jmp_en_xi && ibus_gnt_xi;
    assign rsp_take   = in_wait && ibus_rvalid_xi
                        && !jmp_en_xi && !id_stall;
    assign skid_load  = in_wait && ibus_rvalid_xi
                        && !jmp_en_xi && id_stall;
    assign skid_take  = in_full && skid_full
                        && !jmp_en_xi && !id_stall;
    assign skid_clear = in_full && (jmp_en_xi || !id_stall);
    assign hold_keep  = !jmp_en_xi && id_stall;

    assign ibus_req_xo  = in_req && !jmp_en_xi;
    assign ibus_addr_xo = inst_addr_xi;

    // PC may only advance in the cycle an instruction enters IF/ID.
    assign fetch_hold_req_xo = !(rsp_take || skid_take);

    panxi_if_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .data_in (ibus_rdata_xi),
        .addr_in (addr_q),
        .data    (skid_data),
        .addr    (skid_addr),
        .full    (skid_full)
    );

    // Fetch sequencing: request, await data, drop flushed data, skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (gnt_take) begin
                        addr_q <= inst_addr_xi;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ibus_rvalid_xi) begin
                        if (skid_load)
                            state <= S_FULL;
                        else
                            state <= S_REQ;
                    end else if (jmp_en_xi) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (ibus_rvalid_xi)
                        state <= S_REQ;
                end
                S_FULL: begin
                    if (skid_clear)
                        state <= S_REQ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // IF/ID next value: flush beats load beats hold beats bubble.
    always_comb begin
        if_id_d = if_id_bubble();
        unique case (1'b1)
            jmp_en_xi: if_id_d = if_id_bubble();
            rsp_take: begin
                if_id_d.inst  = ibus_rdata_xi;
                if_id_d.addr  = addr_q;
                if_id_d.valid = 1'b1;
            end
            skid_take: begin
                if_id_d.inst  = skid_data;
                if_id_d.addr  = skid_addr;
                if_id_d.valid = 1'b1;
            end
            hold_keep: if_id_d = if_id_q;
            default:   if_id_d = if_id_bubble();
        endcase
    end

    // IF/ID instruction register.
    always_ff @(posedge clk) begin
        if (rst)
            if_id_q <= if_id_bubble();
        else
            if_id_q <= if_id_d;
    end

    assign inst_xo       = if_id_q.inst;
    assign inst_addr_xo  = if_id_q.addr;
    assign inst_valid_xo = if_id_q.valid;

endmodule
